rst_seq_ctrl: RTL
=================

Name: rst_seq_ctrl

Overview:
Parametrised reset sequencer in the cfg domain, replacing fixed one-shot reset fan-out.
- Holds N_CH channel resets asserted until the PLL reports lock and a minimum hold time has elapsed.
- Releases the channels one by one in index order, with a programmable gap between releases.
- Afterwards services per-channel soft-reset requests, each with a minimum-width stretch.
- Outputs are active-low level resets; each destination domain synchronises its own channel externally.

Parameters:
N_CH, 10, number of reset channels (1..32).
HOLD_CYC, 16, minimum assert cycles for global hold and soft-reset stretch (>=1).
GAP_CYC, 4, cycles between successive channel releases (>=1).
CNT_W, derived clog2(max(HOLD_CYC,GAP_CYC)+1), counter width; not overridable.
CH_W, derived clog2(N_CH) (min 1), channel index width.

Ports:
i_cfg_clk  in  1  sole clock.
i_cfg_rst  in  1  reset; synchronous, active-high.
i_pll_locked  in  1  PLL lock, already synchronous to i_cfg_clk.
i_seq_start  in  1  single-cycle pulse; re-runs the full sequence.
i_soft_rst_req  in  N_CH  per-channel level soft-reset request.
o_ch_rst_n  out  N_CH  per-channel reset, active-low, registered.
o_seq_done  out  1  high when all channels released and sequencer in S_RUN.
o_busy  out  1  high in S_HOLD/S_RELEASE.
o_cur_ch  out  CH_W  next channel index to be released.

Behaviour:
Reset (i_cfg_rst=1 at an edge):
- o_ch_rst_n=0 all; o_seq_done=0; o_busy=1; o_cur_ch=0.
- FSM enters S_HOLD; all counters cleared.
- i_cfg_rst overrides everything, including mid-sequence.

Cycle numbering: cycle 0 = first edge with i_cfg_rst=0.

S_HOLD:
- All channels asserted.
- Hold counter increments each cycle i_pll_locked=1; clears to 0 on any cycle i_pll_locked=0.
- When counter reaches HOLD_CYC-1 with lock high: go to S_RELEASE and release channel 0 on the same edge.
- Result: o_ch_rst_n[0] rises at edge HOLD_CYC when lock is continuous from cycle 0.

S_RELEASE:
- Channel k is released exactly GAP_CYC cycles after channel k-1.
- o_cur_ch increments at each release.
- After channel N_CH-1 is released, the next edge enters S_RUN: o_seq_done=1, o_busy=0.
- Release of channel k occurs at HOLD_CYC + k*GAP_CYC; done at HOLD_CYC + (N_CH-1)*GAP_CYC + 1.
- N_CH=1: done at HOLD_CYC+1.

S_RUN: idle; soft resets serviced.

Loss of lock:
- i_pll_locked=0 in S_RELEASE or S_RUN: next edge returns to S_HOLD.
- All o_ch_rst_n=0, o_seq_done=0, o_cur_ch=0, per-channel stretch state cleared.

i_seq_start:
- In S_RELEASE or S_RUN: same effect as loss of lock.
- In S_HOLD: restarts the hold counter.
- Simultaneous with lock loss: identical result.

Soft reset, per channel k, honoured only once k has been released:
- Request high: o_ch_rst_n[k]=0 from the next edge.
- Channel stays asserted while the request is high, then HOLD_CYC further cycles after the request falls, then releases.
- A request re-asserting during the stretch restarts the stretch on its falling edge.
- Requests on unreleased channels are ignored; no latching.
- Soft resets do not affect o_seq_done or other channels.

All outputs are registered; no combinational input-to-output path.

Decomposition:
- Package rst_seq_pkg: state enum (S_HOLD, S_RELEASE, S_RUN), clog2 function, width-derivation constants.
- Sub-module rst_stretch, instanced N_CH times via generate:
  - inputs: clk, rst, enable (channel released), req;
  - output: rst_n;
  - contains a CNT_W stretch counter.
- Top level holds the FSM, hold/gap counter and channel index.

Test Plan:
1. N_CH=4, HOLD=16, GAP=4, lock high from cycle 0 -> ch0..3 rise at 16/20/24/28; o_seq_done rises at 29; o_busy falls at 29.
2. Lock low at cycles 0..9, high thereafter -> ch0 rises at 26; lock pulse low at cycle 30 -> at 31 all o_ch_rst_n=0 and done=0; sequence reruns with ch0 at 31+16+... relative timing unchanged.
3. In S_RUN, i_soft_rst_req[2] high cycles 100..104 -> ch2 low at edges 101..120, high at 121; ch0/1/3 and o_seq_done unaffected.
4. Soft request on ch3 during S_RELEASE before ch3 is released -> ignored; ch3 released on schedule at cycle 28.
5. i_seq_start pulse in S_RUN at cycle 50 -> cycle 51 all asserted, busy=1, cur_ch=0; ch0 at 67, done at 80.
6. i_cfg_rst asserted at cycle 22 (mid-release) -> next edge all outputs at reset values; sequence restarts from cycle 0 numbering after deassert.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared types and width helpers for the reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2
  } seq_state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int w;
    int v;
    w = 0;
    v = value - 1;
    while (v > 0) begin
      w++;
      v = v >> 1;
    end
    return w;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter must hold values up to max(HOLD_CYC, GAP_CYC).
  function automatic int cnt_width(input int hold_cyc, input int gap_cyc);
    return clog2(max2(hold_cyc, gap_cyc) + 1);
  endfunction

  // Channel index width, never narrower than one bit.
  function automatic int ch_width(input int n_ch);
    return (n_ch > 1) ? clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/rst_stretch.sv
// One channel's reset output: follows the sequencer's release, and once
// released stretches a soft-reset request by HOLD_CYC cycles after it falls.
module rst_stretch #(
  parameter int HOLD_CYC = 16,
  parameter int CNT_W    = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic req,
  output logic rst_n
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);

  logic [CNT_W-1:0] cnt;
  logic             stretching;

  // Channel output flop plus the stretch counter that delays its release.
  // NOTE: state is written with non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      rst_n      <= 1'b0;
      cnt        <= '0;
      stretching <= 1'b0;
    end else if (req) begin
      rst_n      <= 1'b0;
      cnt        <= '0;
      stretching <= 1'b1;
    end else if (stretching) begin
      if (cnt == HOLD_LAST) begin
        rst_n      <= 1'b1;
        cnt        <= '0;
        stretching <= 1'b0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end else begin
      rst_n <= 1'b1;
    end
  end

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds all channels until PLL lock has been stable for
// HOLD_CYC cycles, then releases them in index order GAP_CYC apart, and
// afterwards services per-channel soft-reset requests.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter  int N_CH     = 10,
  parameter  int HOLD_CYC = 16,
  parameter  int GAP_CYC  = 4,
  localparam int CNT_W    = cnt_width(HOLD_CYC, GAP_CYC),
  localparam int CH_W     = ch_width(N_CH)
) (
  input  logic            i_cfg_clk,
  input  logic            i_cfg_rst,
  input  logic            i_pll_locked,
  input  logic            i_seq_start,
  input  logic [N_CH-1:0] i_soft_rst_req,
  output logic [N_CH-1:0] o_ch_rst_n,
  output logic            o_seq_done,
  output logic            o_busy,
  output logic [CH_W-1:0] o_cur_ch
);

  localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(N_CH - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);

  seq_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic [N_CH-1:0] ch_rel;
  logic [N_CH-1:0] ch_rel_next;
  logic            restart;
  logic            release_now;

  // Release/restart decisions, shared by the FSM and the channel stretchers
  // so a channel's output flop moves on the same edge as its release.
  // NOTE: every signal gets a default at the top so no path infers a latch.
  always_comb begin
    restart     = i_seq_start | ~i_pll_locked;
    release_now = 1'b0;
    ch_rel_next = ch_rel;
    case (state)
      S_HOLD:    release_now = !restart && (cnt == HOLD_LAST);
      S_RELEASE: release_now = !restart && !ch_rel[N_CH-1] && (cnt == GAP_LAST);
      default:   release_now = 1'b0;
    endcase
    if (state != S_HOLD && restart) begin
      ch_rel_next = '0;
    end else if (release_now) begin
      for (int k = 0; k < N_CH; k++) begin
        if (o_cur_ch == CH_W'(k)) ch_rel_next[k] = 1'b1;
      end
    end
  end

  // Sequencer FSM with hold/gap counter, channel index and status outputs.
  always_ff @(posedge i_cfg_clk) begin
    if (i_cfg_rst) begin
      state      <= S_HOLD;
      cnt        <= '0;
      ch_rel     <= '0;
      o_cur_ch   <= '0;
      o_seq_done <= 1'b0;
      o_busy     <= 1'b1;
    end else begin
      ch_rel <= ch_rel_next;
      case (state)
        S_HOLD: begin
          if (restart) begin
            cnt <= '0;
          end else if (release_now) begin
            state <= S_RELEASE;
            cnt   <= '0;
            if (o_cur_ch != LAST_CH) o_cur_ch <= o_cur_ch + CH_W'(1);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_RELEASE: begin
          if (restart) begin
            state    <= S_HOLD;
            cnt      <= '0;
            o_cur_ch <= '0;
          end else if (ch_rel[N_CH-1]) begin
            state      <= S_RUN;
            o_seq_done <= 1'b1;
            o_busy     <= 1'b0;
          end else if (release_now) begin
            cnt <= '0;
            if (o_cur_ch != LAST_CH) o_cur_ch <= o_cur_ch + CH_W'(1);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_RUN: begin
          if (restart) begin
            state      <= S_HOLD;
            cnt        <= '0;
            o_cur_ch   <= '0;
            o_seq_done <= 1'b0;
            o_busy     <= 1'b1;
          end
        end
        default: state <= S_HOLD;
      endcase
    end
  end

  // Soft requests only count once the channel was already released.
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    rst_stretch #(
      .HOLD_CYC(HOLD_CYC),
      .CNT_W   (CNT_W)
    ) u_stretch (
      .clk   (i_cfg_clk),
      .rst   (i_cfg_rst),
      .enable(ch_rel_next[k]),
      .req   (i_soft_rst_req[k] & ch_rel[k]),
      .rst_n (o_ch_rst_n[k])
    );
  end

endmodule
